main_memory_responder: RTL and testbench

// - Main-memory responder: the memory-side end of the cache controller's main-memory interface.
// - Services one-cycle request pulses from the cache controller:
//   - block reads (64 B, 16 words) for read-miss refills;
//   - single-word writes for write-through.
// - Uses a word-wide internal storage array and a programmable access latency.
// - Signals completion to the controller with a one-cycle mem_ready pulse.

---
 rtl/main_memory_responder.sv | 113 +++++++++++
 tb/tb_main_memory_responder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/main_memory_responder.sv
// Memory-side responder for the cache controller: 64 B block reads and single-word
// writes against a word-wide array, with a programmable access latency.
module main_memory_responder #(
  parameter int DEPTH_LOG2  = 12,
  parameter int LATENCY     = 4,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               mem_addr,
  input  logic [31:0]               mem_wdata,
  input  logic                      mem_read_req,
  input  logic                      mem_write_req,
  output logic [32*BLOCK_WORDS-1:0] mem_block_out,
  output logic                      mem_ready,
  output logic                      mem_busy,
  output logic                      mem_err
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam int         BLK_W    = 32 * BLOCK_WORDS;
  localparam logic [7:0] LAT_LAST = 8'(LATENCY - 1);

  typedef enum logic [2:0] {IDLE, RD_LAT, RD_BURST, WR_LAT, DONE} state_t;

  state_t                  state;
  logic [7:0]              lat_cnt;
  logic [3:0]              burst_cnt;
  logic [DEPTH_LOG2-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic [31:0]             mem [DEPTH];
  logic [BLK_W-33:0]       burst_buf;
  logic [31:0]             rd_word;
  logic                    wr_commit;
  logic                    unused_addr;

  assign unused_addr = ^{mem_addr[31:DEPTH_LOG2+2], mem_addr[1:0]};
  // Base is block aligned, so the low index bits are simply the burst counter.
  assign rd_word   = mem[{addr_q[DEPTH_LOG2-1:4], burst_cnt}];
  assign wr_commit = (state == WR_LAT) && (lat_cnt == LAT_LAST);

  // Datapath: request capture, storage array and the burst shift buffer (no reset).
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      addr_q  <= mem_read_req ? {mem_addr[DEPTH_LOG2+1:6], 4'b0000} : mem_addr[DEPTH_LOG2+1:2];
      wdata_q <= mem_wdata;
    end
    if (wr_commit) mem[addr_q] <= wdata_q;
    // Words enter at the top and drift down, so word 0 sits lowest after 15 shifts.
    if (state == RD_BURST) burst_buf <= {rd_word, burst_buf[BLK_W-33:32]};
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      lat_cnt       <= '0;
      burst_cnt     <= '0;
      mem_block_out <= '0;
      mem_ready     <= 1'b0;
      mem_busy      <= 1'b0;
      mem_err       <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mem_read_req) begin
            state    <= RD_LAT;
            lat_cnt  <= '0;
            mem_busy <= 1'b1;
            if (mem_write_req) mem_err <= 1'b1;
          end else if (mem_write_req) begin
            state    <= WR_LAT;
            lat_cnt  <= '0;
            mem_busy <= 1'b1;
          end
        end
        RD_LAT: begin
          if (lat_cnt == LAT_LAST) begin
            lat_cnt   <= '0;
            burst_cnt <= '0;
            state     <= RD_BURST;
          end else begin
            lat_cnt <= lat_cnt + 8'd1;
          end
        end
        RD_BURST: begin
          burst_cnt <= burst_cnt + 4'd1;
          if (burst_cnt == 4'hF) begin
            state         <= DONE;
            mem_ready     <= 1'b1;
            mem_block_out <= {rd_word, burst_buf};
          end
        end
        WR_LAT: begin
          if (lat_cnt == LAT_LAST) begin
            lat_cnt   <= '0;
            state     <= DONE;
            mem_ready <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + 8'd1;
          end
        end
        DONE: begin
          state    <= IDLE;
          mem_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// Scoreboard bench for main_memory_responder: expected completions are queued at
// request time and matched against each mem_ready pulse.
module tb_main_memory_responder;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  mem_addr = '0;
  logic [31:0]  mem_wdata = '0;
  logic         mem_read_req = 1'b0;
  logic         mem_write_req = 1'b0;
  logic [511:0] mem_block_out;
  logic         mem_ready;
  logic         mem_busy;
  logic         mem_err;

  main_memory_responder #(.DEPTH_LOG2(12), .LATENCY(LAT), .BLOCK_WORDS(16)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
    .mem_block_out(mem_block_out), .mem_ready(mem_ready),
    .mem_busy(mem_busy), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  typedef struct {
    int           exp_cyc;
    bit           is_read;
    logic [511:0] blk;
    logic [15:0]  mask;
  } exp_t;

  exp_t         sb[$];
  logic [31:0]  model_mem [int];
  logic [511:0] last_blk = '0;
  logic [15:0]  last_mask = 16'hFFFF;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'hFFF);
  endfunction

  // Completion monitor: every mem_ready must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && mem_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_ready", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk(e.is_read ? "rd_ready_cyc" : "wr_ready_cyc", cyc, e.exp_cyc);
        for (int k = 0; k < 16; k++)
          if (e.mask[k]) chk($sformatf("blk_w%0d", k), mem_block_out[32*k +: 32], e.blk[32*k +: 32]);
      end
    end
  end

  // Drive a one-cycle request; if expect_resp, queue its completion.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input bit expect_resp);
    exp_t e;
    @(posedge clk); #1;
    mem_read_req = rd; mem_write_req = wr; mem_addr = a; mem_wdata = d;
    if (expect_resp) begin
      e.is_read = rd;
      if (rd) begin
        int base;
        base = widx(a) & ~15;
        e.exp_cyc = cyc + LAT + 17;
        e.blk = '0; e.mask = '0;
        for (int k = 0; k < 16; k++)
          if (model_mem.exists(base + k)) begin
            e.blk[32*k +: 32] = model_mem[base + k];
            e.mask[k] = 1'b1;
          end
        last_blk = e.blk; last_mask = e.mask;
      end else begin
        e.exp_cyc = cyc + LAT + 1;
        e.blk = last_blk; e.mask = last_mask;
        model_mem[widx(a)] = d;
      end
      sb.push_back(e);
    end
    @(posedge clk); #1;
    mem_read_req = 1'b0; mem_write_req = 1'b0;
    if (expect_resp) chk("busy_after_req", mem_busy, 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      chk("timeout_pending", sb.size(), 0);
      sb.delete();
    end
    #1;
    chk("busy_idle", mem_busy, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy", mem_busy, 0);
    chk("rst_ready", mem_ready, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_block", mem_block_out, '0);

    // Write then read back the containing block.
    issue(0, 1, 32'h0000_0048, 32'hDEAD_BEEF, 1); wait_done();
    issue(1, 0, 32'h0000_0040, 32'h0, 1); wait_done();
    chk("deadbeef_word2", mem_block_out[95:64], 32'hDEAD_BEEF);

    // Full block from an unaligned read address.
    for (int k = 0; k < 16; k++) begin
      issue(0, 1, 32'h1000 + 32'(4*k), 32'h100 + 32'(k), 1); wait_done();
    end
    issue(1, 0, 32'h0000_1024, 32'h0, 1); wait_done();

    // Address wrap modulo depth, plus requests pulsed during the burst.
    issue(0, 1, 32'h0001_0008, 32'h55, 1); wait_done();
    issue(1, 0, 32'h0000_0000, 32'h0, 1);
    repeat (LAT + 2) @(posedge clk);
    #1;
    mem_read_req = 1'b1; mem_write_req = 1'b1; mem_addr = 32'h8; mem_wdata = 32'h99;
    @(posedge clk); #1;
    mem_read_req = 1'b0; mem_write_req = 1'b0;
    wait_done();
    chk("err_ignored_req", mem_err, 0);
    issue(1, 0, 32'h0000_0000, 32'h0, 1); wait_done();

    // Collision: read wins, write dropped, mem_err sticky.
    issue(0, 1, 32'h0000_0080, 32'hA5, 1); wait_done();
    issue(1, 1, 32'h0000_0080, 32'h5A, 1); wait_done();
    chk("err_set", mem_err, 1);
    issue(1, 0, 32'h0000_0080, 32'h0, 1); wait_done();
    chk("err_sticky", mem_err, 1);

    // Reset mid-write: outputs clear at once, write dropped, no completion.
    issue(0, 1, 32'h0000_0200, 32'h11, 1); wait_done();
    issue(0, 1, 32'h0000_0200, 32'h77, 0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("async_busy", mem_busy, 0);
    chk("async_ready", mem_ready, 0);
    chk("async_err", mem_err, 0);
    chk("async_block", mem_block_out, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_blk = '0; last_mask = 16'hFFFF;
    repeat (LAT + 4) @(posedge clk);
    #1;
    chk("post_rst_busy", mem_busy, 0);
    issue(1, 0, 32'h0000_0200, 32'h0, 1); wait_done();
    chk("rst_drop_word", mem_block_out[31:0], 32'h11);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
